// File: rtl/instr_fetch_fsm.sv
// Instruction fetch/sequencer: owns the PC, fetches program words into the IR and
// hands them to the execute FSMs, advancing on their pc_inc/exec_done strobes.
module instr_fetch_fsm #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       MEM_LAT  = 1,
  parameter int unsigned       TIMEOUT  = 15,
  parameter logic [3:0]        HALT_OP  = 4'b1111,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       mem_data,
  input  logic              exec_done,
  input  logic              pc_inc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [15:0]       instruction,
  output logic              IF_active,
  output logic              illegal_op,
  output logic              halted
);

  localparam int unsigned WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_ADDR,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                mem_rd_q, mem_rd_d;
  logic                illegal_q, illegal_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_ADDR;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      mem_rd_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      mem_rd_q   <= mem_rd_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    illegal_d  = 1'b0;

    case (state_q)
      S_ADDR: begin
        wait_cnt_d = '0;
        // mem_rd is registered and resets low, so the first S_ADDR after reset
        // spends one extra cycle raising it before moving on.
        if (mem_rd_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_cnt_d = '0;
        if (wait_cnt_q == WAIT_LAST) begin
          ir_d    = mem_data;
          state_d = (mem_data[15:12] == HALT_OP) ? S_HALT : S_EXEC;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (pc_inc) pc_d = pc_q + ADDR_W'(1);
        if (exec_done) begin
          state_d = S_ADDR;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_ADDR;
          illegal_d = 1'b1;
          pc_d      = pc_d + ADDR_W'(1);
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_ADDR;
    endcase

    mem_rd_d = (state_d == S_ADDR);
  end

  assign mem_addr    = pc_q;
  assign mem_rd      = mem_rd_q;
  assign instruction = ir_q;
  assign IF_active   = (state_q != S_EXEC);
  assign illegal_op  = illegal_q;
  assign halted      = (state_q == S_HALT);

endmodule
